mem_line_adapter: RTL
=====================

MEM_LINE_ADAPTER -- requirements
Module: mem_line_adapter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-low reset; asserted when 0.
REQ-003 SHALL have: mem_address  in  32  CPU byte address (bits [1:0] ignored).
REQ-004 SHALL have: mem_read  in  1 and mem_write  in  1; never both high; held stable until mem_resp.
REQ-005 SHALL have: mem_byte_enable  in  4  and mem_wdata  in  32  store lanes and data.
REQ-006 SHALL have: mem_rdata  out  32 and mem_resp  out  1  one-cycle completion pulse.
REQ-007 SHALL have: pmem_address  out  32  line-aligned, bits [4:0] = 0.
REQ-008 SHALL have: pmem_read  out  1, pmem_write  out  1, pmem_rdata  in  64, pmem_wdata  out  64, pmem_resp  in  1  one pulse per beat.

Function
REQ-009 Line = 32 bytes = 4 beats of 64 bits; beat k carries line bytes [8k+7:8k]; tag = address[31:5].
REQ-010 Internal state: one line buffer, valid bit, 27-bit tag, 2-bit beat counter.
REQ-011 States: IDLE, FILL, MERGE, WB, RESP.
REQ-012 IDLE, mem_read, valid and tag hit -> RESP; mem_resp asserted exactly 1 cycle after the request is first sampled.
REQ-013 IDLE, mem_read miss -> FILL; IDLE, mem_write hit -> MERGE; IDLE, mem_write miss -> FILL.
REQ-014 FILL: pmem_read=1 continuously, pmem_address = {tag_in, 5'b0}; each pmem_resp stores pmem_rdata in beat counter slot and increments counter.
REQ-015 FILL, pmem_resp with counter=3: set valid, load tag, counter wraps to 0; -> RESP if read, -> MERGE if write.
REQ-016 MERGE (1 cycle): writes mem_wdata lanes where mem_byte_enable bit=1 into word address[4:2]; other bytes unchanged; -> WB.
REQ-017 WB: pmem_write=1 continuously, pmem_wdata = buffer beat[counter]; counter increments on pmem_resp; after beat 3 -> RESP.
REQ-018 mem_byte_enable=0000 on write SHALL still perform the full WB with unchanged data.
REQ-019 RESP: mem_resp=1 for one cycle, mem_rdata = buffer word address[4:2]; -> IDLE.
REQ-020 mem_rdata SHALL hold the last returned word outside RESP.
REQ-021 pmem_read and pmem_write SHALL never be high together; both low in IDLE, MERGE, RESP.
REQ-022 pmem_resp outside FILL/WB SHALL be ignored.
REQ-023 A request in RESP cycle SHALL NOT be sampled; the next request is sampled no earlier than IDLE.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, valid=0, counter=0, mem_resp=0, pmem_read=0, pmem_write=0, mem_rdata=0, pmem_address=0.
REQ-025 Reset mid-FILL/WB SHALL abandon the burst; no partial line marked valid; buffer data contents unspecified.
REQ-026 First request after reset release SHALL be treated as a miss.

Configuration
REQ-027 Macro LINE_BUF_HIT_EN: defined -> hit path per REQ-012/013 active.
REQ-028 LINE_BUF_HIT_EN undefined -> hit never detected; every read FILLs, every write FILLs then MERGE then WB; results identical, latency only differs.

Structure
REQ-029 Package pmem_types SHALL hold the state enum, LINE_BYTES=32, BEAT_BITS=64, NUM_BEATS=4, TAG_WIDTH=27.
REQ-030 Sub-module line_store SHALL hold the 256-bit line: beat write port, byte-enabled word write port, word and beat read ports.
REQ-031 FSM and counter SHALL reside in mem_line_adapter.

Verification
REQ-032 Reset, read 0x0000_0044, memory beats line 0x40 = {beat0..3} -> pmem_address=0x40, 4 beats, mem_resp once, mem_rdata = beat0[63:32].
REQ-033 Then read 0x0000_0058 -> no pmem_read, mem_resp 1 cycle after request, data = beat3[31:0].
REQ-034 Write 0x0000_0048, be=0101, wdata=0xAABBCCDD over line 0x40 -> WB beat1 low word shows bytes 0 and 2 replaced (0x..BB..DD pattern), other beats unchanged.
REQ-035 Write miss 0x0000_1000, be=1111 -> FILL line 0x1000 then WB line 0x1000 with merged word; mem_resp once.
REQ-036 rst low during FILL beat 2 -> pmem_read low immediately; subsequent read of same address refetches all 4 beats.
REQ-037 Build without LINE_BUF_HIT_EN, repeat REQ-033 -> full 4-beat refetch, same mem_rdata.

Source files
------------

// File: rtl/mem_line_adapter_pkg.sv
// pmem_types: shared FSM state encoding and line geometry for mem_line_adapter.
package pmem_types;
    typedef enum logic [2:0] {IDLE, FILL, MERGE, WB, RESP} state_t;
    localparam int LINE_BYTES = 32;
    localparam int BEAT_BITS  = 64;
    localparam int NUM_BEATS  = 4;
    localparam int TAG_WIDTH  = 27;
    localparam int LINE_BITS  = LINE_BYTES * 8;
endpackage

// File: rtl/mem_line_adapter_line_store.sv
// line_store: one 256-bit line with a beat write port, a byte-enabled word write port,
// and combinational word/beat read ports.
module line_store
    import pmem_types::*;
(
    input  logic                 clk,
    input  logic                 beat_we,
    input  logic [1:0]           beat_idx,
    input  logic [BEAT_BITS-1:0] beat_wdata,
    input  logic                 word_we,
    input  logic [2:0]           word_idx,
    input  logic [3:0]           word_be,
    input  logic [31:0]          word_wdata,
    output logic [31:0]          word_rdata,
    output logic [BEAT_BITS-1:0] beat_rdata
);
    logic [LINE_BITS-1:0] line;

    // Line contents carry no reset: data is meaningless until a fill marks it valid.
    always_ff @(posedge clk) begin
        if (beat_we) line[beat_idx*BEAT_BITS +: BEAT_BITS] <= beat_wdata;
        for (int b = 0; b < 4; b++)
            if (word_we && word_be[b]) line[word_idx*32 + b*8 +: 8] <= word_wdata[b*8 +: 8];
    end

    assign word_rdata = line[word_idx*32 +: 32];
    assign beat_rdata = line[beat_idx*BEAT_BITS +: BEAT_BITS];
endmodule

// File: rtl/mem_line_adapter.sv
// mem_line_adapter: 32-bit CPU port onto a 4x64-bit line-burst memory through a one-line buffer.
// Define LINE_BUF_HIT_EN to serve buffer hits without a refill.
module mem_line_adapter
    import pmem_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          mem_address,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [3:0]           mem_byte_enable,
    input  logic [31:0]          mem_wdata,
    output logic [31:0]          mem_rdata,
    output logic                 mem_resp,
    output logic [31:0]          pmem_address,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic [BEAT_BITS-1:0] pmem_rdata,
    output logic [BEAT_BITS-1:0] pmem_wdata,
    input  logic                 pmem_resp
);
`ifdef LINE_BUF_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif
    state_t               state, state_nx;
    logic                 valid, hit, last_beat, unused;
    logic [TAG_WIDTH-1:0] tag, tag_in;
    logic [1:0]           cnt;
    logic [31:0]          rdata_q, word_rd;

    assign unused    = &{1'b0, mem_address[1:0]};
    assign tag_in    = mem_address[31:5];
    assign hit       = HIT_EN && valid && (tag == tag_in);
    assign last_beat = pmem_resp && (cnt == 2'(NUM_BEATS - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (mem_read || mem_write) state_nx = !hit ? FILL : mem_read ? RESP : MERGE;
            FILL:    if (last_beat) state_nx = mem_read ? RESP : MERGE;
            MERGE:   state_nx = WB;
            WB:      if (last_beat) state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    assign pmem_read    = (state == FILL);
    assign pmem_write   = (state == WB);
    assign mem_resp     = (state == RESP);
    assign pmem_address = (pmem_read || pmem_write) ? {tag_in, 5'b0} : '0;
    assign mem_rdata    = mem_resp ? word_rd : rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            tag     <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if ((pmem_read || pmem_write) && pmem_resp) cnt <= cnt + 2'd1;
            if (pmem_read && last_beat) begin
                valid <= 1'b1;
                tag   <= tag_in;
            end
            if (mem_resp) rdata_q <= word_rd;
        end
    end

    line_store u_store (
        .clk        (clk),
        .beat_we    (pmem_read && pmem_resp),
        .beat_idx   (cnt),
        .beat_wdata (pmem_rdata),
        .word_we    (state == MERGE),
        .word_idx   (mem_address[4:2]),
        .word_be    (mem_byte_enable),
        .word_wdata (mem_wdata),
        .word_rdata (word_rd),
        .beat_rdata (pmem_wdata)
    );
endmodule
